// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the commit-trace recorder: FSM state encodings and
// trace-entry field layout helpers (entry = {tap, inst, pc, cycle}, cycle in LSBs).
package cpu_trace_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REC  = 2'd1,
      ST_HOLD = 2'd2
   } trace_state_e;

   localparam int PC_W    = 32;
   localparam int INST_W  = 32;
   localparam int TAP_W   = 32;
   localparam int CYC_OFF = 0;

   function automatic int entry_w(input int cnt_w, input int num_tap);
      return cnt_w + PC_W + INST_W + num_tap * TAP_W;
   endfunction

   function automatic int pc_off(input int cnt_w);
      return cnt_w;
   endfunction

   function automatic int inst_off(input int cnt_w);
      return cnt_w + PC_W;
   endfunction

   function automatic int tap_off(input int cnt_w);
      return cnt_w + PC_W + INST_W;
   endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace store: synchronous write, registered read. The read
// register only updates on a read, so its output holds between reads.
module trace_ram #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 192,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [WIDTH-1:0] rdata_r;

   // write port; the array itself carries no reset
   always_ff @(posedge clk_in) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   // registered read port, cleared on reset
   always_ff @(posedge clk_in) begin
      if (!reset) begin
         rdata_r <= {WIDTH{1'b0}};
      end else if (re) begin
         rdata_r <= mem_r[raddr];
      end else begin
         rdata_r <= rdata_r;
      end
   end

   assign rdata = rdata_r;

endmodule

// File: rtl/cpu_trace_recorder.sv
// Commit-trace recorder: captures {cycle, pc, inst, taps} per commit into a circular
// buffer and drains it oldest-first. Optional PC window filter: TRACE_PC_FILTER_EN.
module cpu_trace_recorder
   import cpu_trace_pkg::*;
#(
   parameter int DEPTH       = 64,
   parameter int CYCLE_LIMIT = 10000,
   parameter int CNT_W       = 32,
   parameter int NUM_TAP     = 4,
   parameter int WRAP_MODE   = 1
) (
   input  logic                      clk_in,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      stop,
   input  logic                      clear,
   input  logic                      valid_in,
   input  logic [31:0]               pc_in,
   input  logic [31:0]               inst_in,
   input  logic [NUM_TAP*32-1:0]     tap_in,
`ifdef TRACE_PC_FILTER_EN
   input  logic [31:0]               filter_lo,
   input  logic [31:0]               filter_hi,
`endif
   input  logic                      rd_req,
   output logic                      rd_valid,
   output logic [CNT_W-1:0]          rd_cycle,
   output logic [31:0]               rd_pc,
   output logic [31:0]               rd_inst,
   output logic [NUM_TAP*32-1:0]     rd_tap,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      recording,
   output logic                      done,
   output logic                      overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = entry_w(CNT_W, NUM_TAP);

   localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
   localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]    CNT_FULL = CW'(DEPTH);
   localparam logic [CW-1:0]    CNT_LAST = CW'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CYC_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CYC_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(CYCLE_LIMIT - 1);

   trace_state_e     state_r;
   trace_state_e     state_nx_s;
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic [CNT_W-1:0] cycle_r;
   logic             overflow_r;
   logic             full_hold_r;
   logic             rd_valid_r;

   logic             pc_ok_s;
   logic             commit_s;
   logic             full_s;
   logic             limit_hit_s;
   logic             fill_stop_s;
   logic             rd_fire_s;
   logic [EW-1:0]    wdata_s;
   logic [EW-1:0]    rdata_s;

`ifdef TRACE_PC_FILTER_EN
   assign pc_ok_s = (pc_in >= filter_lo) && (pc_in <= filter_hi);
`else
   assign pc_ok_s = 1'b1;
`endif

   assign commit_s    = reset && !clear && (state_r == ST_REC) && valid_in && pc_ok_s;
   assign full_s      = (count_r == CNT_FULL);
   assign limit_hit_s = (CYCLE_LIMIT != 0) && (cycle_r == LIMIT_M1);
   // in stop-when-full mode the write that fills the buffer also ends recording
   assign fill_stop_s = (WRAP_MODE == 0) && commit_s && (count_r == CNT_LAST);
   assign rd_fire_s   = reset && !clear && (state_r == ST_HOLD) && rd_req && (count_r != {CW{1'b0}});
   assign wdata_s     = {tap_in, inst_in, pc_in, cycle_r};

   trace_ram #(
      .DEPTH (DEPTH),
      .WIDTH (EW),
      .AW    (AW)
   ) u_ram (
      .clk_in (clk_in),
      .reset  (reset),
      .we     (commit_s),
      .waddr  (wr_ptr_r),
      .wdata  (wdata_s),
      .re     (rd_fire_s),
      .raddr  (rd_ptr_r),
      .rdata  (rdata_s)
   );

   // state register
   always_ff @(posedge clk_in) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // next-state decode; clear overrides every other request
   always_comb begin
      state_nx_s = state_r;
      if (clear) begin
         state_nx_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) state_nx_s = ST_REC;
               else       state_nx_s = ST_IDLE;
            end
            ST_REC: begin
               if (stop || limit_hit_s || fill_stop_s) state_nx_s = ST_HOLD;
               else                                    state_nx_s = ST_REC;
            end
            ST_HOLD: state_nx_s = ST_HOLD;
            default: state_nx_s = ST_IDLE;
         endcase
      end
   end

   // pointers, occupancy, cycle stamp, overflow and read strobe
   always_ff @(posedge clk_in) begin
      if (!reset || clear) begin
         wr_ptr_r    <= {AW{1'b0}};
         rd_ptr_r    <= {AW{1'b0}};
         count_r     <= {CW{1'b0}};
         cycle_r     <= {CNT_W{1'b0}};
         overflow_r  <= 1'b0;
         full_hold_r <= 1'b0;
         rd_valid_r  <= 1'b0;
      end else begin
         rd_valid_r <= rd_fire_s;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  wr_ptr_r    <= {AW{1'b0}};
                  rd_ptr_r    <= {AW{1'b0}};
                  count_r     <= {CW{1'b0}};
                  cycle_r     <= {CNT_W{1'b0}};
                  overflow_r  <= 1'b0;
                  full_hold_r <= 1'b0;
               end
            end
            ST_REC: begin
               if (cycle_r != CYC_MAX) begin
                  cycle_r <= cycle_r + CYC_ONE;
               end
               if (commit_s) begin
                  wr_ptr_r <= wr_ptr_r + PTR_ONE;
                  // a full buffer here only happens in overwrite mode: drop the oldest
                  if (full_s) begin
                     rd_ptr_r   <= rd_ptr_r + PTR_ONE;
                     overflow_r <= 1'b1;
                  end else begin
                     count_r <= count_r + CNT_ONE;
                  end
               end
               if (fill_stop_s) begin
                  full_hold_r <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (full_hold_r && valid_in && pc_ok_s) begin
                  overflow_r <= 1'b1;
               end
               if (rd_fire_s) begin
                  rd_ptr_r <= rd_ptr_r + PTR_ONE;
                  count_r  <= count_r - CNT_ONE;
               end
            end
            default: begin
               wr_ptr_r <= wr_ptr_r;
            end
         endcase
      end
   end

   assign rd_valid  = rd_valid_r;
   assign rd_cycle  = rdata_s[CYC_OFF +: CNT_W];
   assign rd_pc     = rdata_s[pc_off(CNT_W) +: PC_W];
   assign rd_inst   = rdata_s[inst_off(CNT_W) +: INST_W];
   assign rd_tap    = rdata_s[tap_off(CNT_W) +: NUM_TAP*TAP_W];
   assign count     = count_r;
   assign recording = (state_r == ST_REC);
   assign done      = (state_r == ST_HOLD);
   assign overflow  = overflow_r;

endmodule

// File: tb/tb_cpu_trace_recorder.sv
// Self-checking bench: three recorder configurations share one stimulus stream and are
// checked against a queue-style reference model, plus directed tables and sequences.
`timescale 1ns/1ps
module tb_cpu_trace_recorder;

   localparam int ND = 3;
   localparam logic [31:0] PC0 = 32'h0040_0000;
   localparam int P_DEPTH [ND] = '{8, 8, 32};
   localparam int P_LIMIT [ND] = '{0, 0, 20};
   localparam int P_CMAX  [ND] = '{255, 65535, 65535};
   localparam int P_WRAP  [ND] = '{1, 0, 1};

   logic clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   logic        reset, start, stop, clear, valid_in, rd_req;
   logic [31:0] pc_in, inst_in;
   logic [63:0] tap_in;
`ifdef TRACE_PC_FILTER_EN
   logic [31:0] filter_lo, filter_hi;
`endif

   logic        rv_a, rv_b, rv_c, rec_a, rec_b, rec_c, done_a, done_b, done_c, ovf_a, ovf_b, ovf_c;
   logic [7:0]  cyc_a;
   logic [15:0] cyc_b, cyc_c;
   logic [31:0] pc_a, pc_b, pc_c, inst_a, inst_b, inst_c;
   logic [63:0] tap_a, tap_b, tap_c;
   logic [3:0]  cnt_a, cnt_b;
   logic [5:0]  cnt_c;

   cpu_trace_recorder #(.DEPTH(8), .CYCLE_LIMIT(0), .CNT_W(8), .NUM_TAP(2), .WRAP_MODE(1)) u_a (
      .clk_in(clk_in), .reset(reset), .start(start), .stop(stop), .clear(clear),
      .valid_in(valid_in), .pc_in(pc_in), .inst_in(inst_in), .tap_in(tap_in),
`ifdef TRACE_PC_FILTER_EN
      .filter_lo(filter_lo), .filter_hi(filter_hi),
`endif
      .rd_req(rd_req), .rd_valid(rv_a), .rd_cycle(cyc_a), .rd_pc(pc_a), .rd_inst(inst_a),
      .rd_tap(tap_a), .count(cnt_a), .recording(rec_a), .done(done_a), .overflow(ovf_a));

   cpu_trace_recorder #(.DEPTH(8), .CYCLE_LIMIT(0), .CNT_W(16), .NUM_TAP(2), .WRAP_MODE(0)) u_b (
      .clk_in(clk_in), .reset(reset), .start(start), .stop(stop), .clear(clear),
      .valid_in(valid_in), .pc_in(pc_in), .inst_in(inst_in), .tap_in(tap_in),
`ifdef TRACE_PC_FILTER_EN
      .filter_lo(filter_lo), .filter_hi(filter_hi),
`endif
      .rd_req(rd_req), .rd_valid(rv_b), .rd_cycle(cyc_b), .rd_pc(pc_b), .rd_inst(inst_b),
      .rd_tap(tap_b), .count(cnt_b), .recording(rec_b), .done(done_b), .overflow(ovf_b));

   cpu_trace_recorder #(.DEPTH(32), .CYCLE_LIMIT(20), .CNT_W(16), .NUM_TAP(2), .WRAP_MODE(1)) u_c (
      .clk_in(clk_in), .reset(reset), .start(start), .stop(stop), .clear(clear),
      .valid_in(valid_in), .pc_in(pc_in), .inst_in(inst_in), .tap_in(tap_in),
`ifdef TRACE_PC_FILTER_EN
      .filter_lo(filter_lo), .filter_hi(filter_hi),
`endif
      .rd_req(rd_req), .rd_valid(rv_c), .rd_cycle(cyc_c), .rd_pc(pc_c), .rd_inst(inst_c),
      .rd_tap(tap_c), .count(cnt_c), .recording(rec_c), .done(done_c), .overflow(ovf_c));

   logic [31:0] o_cnt [ND];
   logic [31:0] o_cyc [ND];
   logic [31:0] o_pc  [ND];
   logic [31:0] o_inst[ND];
   logic [63:0] o_tap [ND];
   logic        o_rv  [ND];
   logic        o_rec [ND];
   logic        o_done[ND];
   logic        o_ovf [ND];

   assign o_cnt[0] = 32'(cnt_a);  assign o_cnt[1] = 32'(cnt_b);  assign o_cnt[2] = 32'(cnt_c);
   assign o_cyc[0] = 32'(cyc_a);  assign o_cyc[1] = 32'(cyc_b);  assign o_cyc[2] = 32'(cyc_c);
   assign o_pc[0]  = pc_a;        assign o_pc[1]  = pc_b;        assign o_pc[2]  = pc_c;
   assign o_inst[0] = inst_a;     assign o_inst[1] = inst_b;     assign o_inst[2] = inst_c;
   assign o_tap[0] = tap_a;       assign o_tap[1] = tap_b;       assign o_tap[2] = tap_c;
   assign o_rv[0]  = rv_a;        assign o_rv[1]  = rv_b;        assign o_rv[2]  = rv_c;
   assign o_rec[0] = rec_a;       assign o_rec[1] = rec_b;       assign o_rec[2] = rec_c;
   assign o_done[0] = done_a;     assign o_done[1] = done_b;     assign o_done[2] = done_c;
   assign o_ovf[0] = ovf_a;       assign o_ovf[1] = ovf_b;       assign o_ovf[2] = ovf_c;

   // Reference model: each recorder is a bounded FIFO of commit records
   typedef struct packed {
      logic [31:0] cyc;
      logic [31:0] pc;
      logic [31:0] inst;
      logic [63:0] tap;
   } entry_t;

   entry_t m_buf [ND][128];
   entry_t m_rd  [ND];
   int     m_st  [ND];   // 0 idle, 1 recording, 2 holding
   int     m_cyc [ND];
   int     m_head[ND];
   int     m_tail[ND];
   bit     m_ovf [ND];
   bit     m_fh  [ND];
   bit     m_rv  [ND];

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s dut%0d @%0t: got %0h, expected %0h", name, d, $time, act, exp);
      end
   endtask

   task automatic model_empty(input int d);
      m_head[d] = 0; m_tail[d] = 0; m_cyc[d] = 0; m_ovf[d] = 1'b0; m_fh[d] = 1'b0;
   endtask

   task automatic model_step();
      int size;
      bit rec, go_hold;
      for (int d = 0; d < ND; d++) begin
         size = m_tail[d] - m_head[d];
         rec = valid_in;
`ifdef TRACE_PC_FILTER_EN
         rec = rec && (pc_in >= filter_lo) && (pc_in <= filter_hi);
`endif
         m_rv[d] = 1'b0;
         if (!reset) begin
            m_st[d] = 0; model_empty(d); m_rd[d] = '0;
         end else if (clear) begin
            m_st[d] = 0; model_empty(d);
         end else if (m_st[d] == 0) begin
            if (start) begin m_st[d] = 1; model_empty(d); end
         end else if (m_st[d] == 1) begin
            go_hold = stop || (P_LIMIT[d] != 0 && m_cyc[d] == P_LIMIT[d] - 1);
            if (rec) begin
               m_buf[d][m_tail[d] % 128] = {32'(m_cyc[d]), pc_in, inst_in, tap_in};
               m_tail[d]++;
               if (size == P_DEPTH[d]) begin
                  m_head[d]++; m_ovf[d] = 1'b1;
               end else if (P_WRAP[d] == 0 && size + 1 == P_DEPTH[d]) begin
                  go_hold = 1'b1; m_fh[d] = 1'b1;
               end
            end
            if (m_cyc[d] < P_CMAX[d]) m_cyc[d]++;
            if (go_hold) m_st[d] = 2;
         end else begin
            if (m_fh[d] && rec) m_ovf[d] = 1'b1;
            if (rd_req && size > 0) begin
               m_rv[d] = 1'b1;
               m_rd[d] = m_buf[d][m_head[d] % 128];
               m_head[d]++;
            end
         end
      end
   endtask

   task automatic compare_all();
      for (int d = 0; d < ND; d++) begin
         chk("count", d, o_cnt[d], 64'(m_tail[d] - m_head[d]));
         chk("recording", d, o_rec[d], m_st[d] == 1);
         chk("done", d, o_done[d], m_st[d] == 2);
         chk("overflow", d, o_ovf[d], m_ovf[d]);
         chk("rd_valid", d, o_rv[d], m_rv[d]);
         chk("rd_cycle", d, o_cyc[d], m_rd[d].cyc);
         chk("rd_pc", d, o_pc[d], m_rd[d].pc);
         chk("rd_inst", d, o_inst[d], m_rd[d].inst);
         chk("rd_tap", d, o_tap[d], m_rd[d].tap);
      end
   endtask

   task automatic step();
      model_step();
      @(posedge clk_in);
      #1;
      compare_all();
   endtask

   task automatic drive(input bit s, input bit p, input bit c, input bit v, input bit r, input logic [31:0] pc);
      start = s; stop = p; clear = c; valid_in = v; rd_req = r;
      pc_in = pc; inst_in = ~pc; tap_in = {pc + 32'd1, pc + 32'd2};
   endtask

   typedef struct {
      bit start, stop, clear, valid, rd;
      logic [31:0] pc;
      int cnt;
      bit rec, done, ovf, rv;
      logic [31:0] rpc;
   } vec_t;

   function automatic vec_t mk(bit s, bit p, bit c, bit v, bit r, logic [31:0] pc,
                               int cnt, bit rec, bit dn, bit ovf, bit rv, logic [31:0] rpc);
      vec_t t;
      t.start = s; t.stop = p; t.clear = c; t.valid = v; t.rd = r; t.pc = pc;
      t.cnt = cnt; t.rec = rec; t.done = dn; t.ovf = ovf; t.rv = rv; t.rpc = rpc;
      return t;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[$];

      // Expected behaviour of the 8-deep overwrite recorder (dut0)
      tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0, 0, 1, 0, 0, 0, 32'h0));
      for (int k = 0; k < 10; k++)
         tbl.push_back(mk(0, 0, 0, 1, 0, PC0 + 32'(4 * k), (k < 8) ? k + 1 : 8, 1, 0, k >= 8, 0, 32'h0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0, 8, 0, 1, 1, 0, 32'h0));
      for (int j = 0; j < 6; j++)
         tbl.push_back(mk(0, 0, 0, 0, 1, 32'h0, 7 - j, 0, 1, 1, 1, PC0 + 32'(8 + 4 * j)));
      tbl.push_back(mk(0, 0, 1, 0, 1, 32'h0, 0, 0, 0, 0, 0, 32'h0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0, 0, 1, 0, 0, 0, 32'h0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0, 0, 0, 1, 0, 0, 32'h0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 32'h0, 0, 0, 1, 0, 0, 32'h0));

`ifdef TRACE_PC_FILTER_EN
      filter_lo = 32'h0;
      filter_hi = 32'hFFFF_FFFF;
`endif
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 32'h0);
      step();
      step();
      chk("reset_count", 0, o_cnt[0], 64'd0);
      chk("reset_rd_valid", 0, o_rv[0], 64'd0);
      reset = 1'b1;
      step();

      foreach (tbl[i]) begin
         drive(tbl[i].start, tbl[i].stop, tbl[i].clear, tbl[i].valid, tbl[i].rd, tbl[i].pc);
         step();
         chk("tbl_count", 0, o_cnt[0], 64'(tbl[i].cnt));
         chk("tbl_recording", 0, o_rec[0], tbl[i].rec);
         chk("tbl_done", 0, o_done[0], tbl[i].done);
         chk("tbl_overflow", 0, o_ovf[0], tbl[i].ovf);
         chk("tbl_rd_valid", 0, o_rv[0], tbl[i].rv);
         if (tbl[i].rv) chk("tbl_rd_pc", 0, o_pc[0], tbl[i].rpc);
      end

      // Reset while recording five entries
      drive(0, 0, 1, 0, 0, 32'h0); step();
      drive(1, 0, 0, 0, 0, 32'h0); step();
      for (int k = 0; k < 5; k++) begin drive(0, 0, 0, 1, 0, PC0 + 32'(4 * k)); step(); end
      chk("pre_reset_count", 0, o_cnt[0], 64'd5);
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 32'h0);
      step();
      chk("mid_reset_count", 0, o_cnt[0], 64'd0);
      chk("mid_reset_recording", 0, o_rec[0], 64'd0);
      chk("mid_reset_done", 0, o_done[0], 64'd0);
      chk("mid_reset_rd_pc", 0, o_pc[0], 64'd0);
      reset = 1'b1;
      step();

      // Stop-when-full recorder: ninth commit lands in HOLD and is counted as lost
      drive(1, 0, 0, 0, 0, 32'h0); step();
      for (int k = 0; k < 9; k++) begin
         drive(0, 0, 0, 1, 0, PC0 + 32'(4 * k));
         step();
         if (k == 7) chk("full_hold", 1, o_done[1], 64'd1);
         if (k == 7) chk("full_no_ovf", 1, o_ovf[1], 64'd0);
         if (k == 8) chk("full_ovf", 1, o_ovf[1], 64'd1);
      end
      for (int j = 0; j < 8; j++) begin
         drive(0, 0, 0, 0, 1, 32'h0);
         step();
         chk("full_rd_valid", 1, o_rv[1], 64'd1);
         chk("full_rd_pc", 1, o_pc[1], 64'(PC0 + 32'(4 * j)));
      end

      // Cycle limit of 20 on the 32-deep recorder
      drive(0, 0, 1, 0, 0, 32'h0); step();
      drive(1, 0, 0, 0, 0, 32'h0); step();
      for (int k = 0; k < 24; k++) begin
         drive(0, 0, 0, 1, 0, PC0 + 32'(4 * k));
         step();
         if (k == 18) chk("limit_still_rec", 2, o_rec[2], 64'd1);
         if (k == 19) chk("limit_hold", 2, o_done[2], 64'd1);
      end
      chk("limit_count", 2, o_cnt[2], 64'd20);
      for (int j = 0; j < 20; j++) begin
         drive(0, 0, 0, 0, 1, 32'h0);
         step();
         chk("limit_stamp", 2, o_cyc[2], 64'(j));
      end

      // Cycle counter saturation on the 8-bit stamp recorder
      drive(0, 0, 1, 0, 0, 32'h0); step();
      drive(1, 0, 0, 0, 0, 32'h0); step();
      drive(0, 0, 0, 0, 0, 32'h0);
      for (int k = 0; k < 300; k++) step();
      drive(0, 0, 0, 1, 0, 32'h1234_5678); step();
      drive(0, 1, 0, 0, 0, 32'h0); step();
      drive(0, 0, 0, 0, 1, 32'h0); step();
      chk("sat_stamp", 0, o_cyc[0], 64'd255);

`ifdef TRACE_PC_FILTER_EN
      // PC window filter keeps only 0x..10..0x..18
      drive(0, 0, 1, 0, 0, 32'h0); step();
      filter_lo = 32'h0040_0010;
      filter_hi = 32'h0040_0018;
      drive(1, 0, 0, 0, 0, 32'h0); step();
      for (int k = 0; k < 9; k++) begin drive(0, 0, 0, 1, 0, PC0 + 32'(4 * k)); step(); end
      drive(0, 1, 0, 0, 0, 32'h0); step();
      chk("filt_count", 0, o_cnt[0], 64'd3);
      for (int j = 0; j < 3; j++) begin
         drive(0, 0, 0, 0, 1, 32'h0);
         step();
         chk("filt_stamp", 0, o_cyc[0], 64'(4 + j));
         chk("filt_pc", 0, o_pc[0], 64'(PC0 + 32'(16 + 4 * j)));
      end
      filter_lo = 32'h0040_0010;
      filter_hi = 32'h0040_0030;
`endif

      // Randomised traffic against the model
      for (int n = 0; n < 3000; n++) begin
         reset    = ($urandom_range(0, 199) != 0);
         start    = ($urandom_range(0, 19) == 0);
         stop     = ($urandom_range(0, 39) == 0);
         clear    = ($urandom_range(0, 149) == 0);
         valid_in = ($urandom_range(0, 9) < 7);
         rd_req   = ($urandom_range(0, 1) == 1);
         pc_in    = PC0 + 32'(4 * $urandom_range(0, 15));
         inst_in  = $urandom;
         tap_in   = {$urandom, $urandom};
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
